// File: rtl/ctrl_multiciclo.sv
// Multicycle control unit for the nRISC processor.
// Steps every instruction through FETCH / DECODE / EXEC / MEM / WB.
// It drives the ULA operation select and the datapath write enables.
// Memory accesses use a request/ready pair. A request that waits too long
// raises a sticky fault and parks the unit in HALT.
// Handshake: a request (mem_rd or mem_wr) stays high for as long as the unit
// is in FETCH or MEM. The request completes in the cycle where mem_ready is
// high. The request is abandoned if TIMEOUT consecutive cycles pass without
// mem_ready. mem_ready is ignored in every other state.
module ctrl_multiciclo #(
   parameter int TIMEOUT = 15,
   parameter int CNT_W   = 16
) (
   input  logic             c,
   input  logic             reset,
   input  logic [7:0]       instr,
   input  logic             zero,
   input  logic             mem_ready,
   output logic [1:0]       ULAOp,
   output logic             mem_rd,
   output logic             mem_wr,
   output logic             ir_we,
   output logic             pc_we,
   output logic [1:0]       pc_src,
   output logic             reg_we,
   output logic             wb_sel,
   output logic             halted,
   output logic             fault,
   output logic             illegal,
   output logic [CNT_W-1:0] retired,
   output logic [2:0]       dbg_state
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5
   } state_t;

   // Last wait-counter value that still allows one more cycle of waiting
   localparam logic [7:0] LP_TMO_LAST = 8'(TIMEOUT - 1);

   state_t           r_state;
   state_t           w_next_state;
   logic [7:0]       r_wait;
   logic             r_fault;
   logic [CNT_W-1:0] r_retired;

   // Opcode classes; instr is stable from DECODE onward (IR loaded in FETCH)
   logic [3:0] w_opcode;
   logic       w_is_alu;
   logic       w_is_ld;
   logic       w_is_st;
   logic       w_is_beq;
   logic       w_is_jmp;
   logic       w_is_halt;
   logic       w_is_illegal;
   logic       w_wait_state;
   logic       w_timeout;
   logic       w_retire;
   logic       w_unused_ok;

   assign w_opcode     = instr[7:4];
   assign w_is_alu     = (w_opcode <= 4'h3);
   assign w_is_ld      = (w_opcode == 4'h4);
   assign w_is_st      = (w_opcode == 4'h5);
   assign w_is_beq     = (w_opcode == 4'h6);
   assign w_is_jmp     = (w_opcode == 4'h7);
   assign w_is_halt    = (w_opcode == 4'hF);
   assign w_is_illegal = (w_opcode >= 4'h8) && (w_opcode <= 4'hE);

   // Register fields are consumed by the datapath, not by the controller
   assign w_unused_ok  = ^instr[3:0];

   // A request is outstanding only in FETCH and MEM
   assign w_wait_state = (r_state == S_FETCH) || (r_state == S_MEM);

   // Timeout fires on the TIMEOUT-th idle cycle; a late ready still wins
   assign w_timeout    = w_wait_state && !mem_ready && (r_wait == LP_TMO_LAST);

   // One pulse per completed instruction, in its final cycle
   always_comb begin
      w_retire = 1'b0;
      case (r_state)
         S_DECODE: w_retire = w_is_jmp || w_is_illegal;
         S_EXEC:   w_retire = w_is_beq;
         S_MEM:    w_retire = mem_ready && !w_is_ld;
         S_WB:     w_retire = 1'b1;
         default:  w_retire = 1'b0;
      endcase
   end

   // State register
   always_ff @(posedge c) begin
      if (reset) begin
         r_state <= S_FETCH;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_FETCH: begin
            if (mem_ready) begin
               w_next_state = S_DECODE;
            end else if (w_timeout) begin
               w_next_state = S_HALT;
            end
         end
         S_DECODE: begin
            if (w_is_halt) begin
               w_next_state = S_HALT;
            end else if (w_is_alu || w_is_ld || w_is_st || w_is_beq) begin
               w_next_state = S_EXEC;
            end else begin
               w_next_state = S_FETCH;
            end
         end
         S_EXEC: begin
            if (w_is_alu) begin
               w_next_state = S_WB;
            end else if (w_is_ld || w_is_st) begin
               w_next_state = S_MEM;
            end else begin
               w_next_state = S_FETCH;
            end
         end
         S_MEM: begin
            if (mem_ready) begin
               w_next_state = w_is_ld ? S_WB : S_FETCH;
            end else if (w_timeout) begin
               w_next_state = S_HALT;
            end
         end
         S_WB:    w_next_state = S_FETCH;
         S_HALT:  w_next_state = S_HALT;
         default: w_next_state = S_FETCH;
      endcase
   end

   // Output decode; everything is held low while reset is asserted
   always_comb begin
      ULAOp   = 2'b00;
      mem_rd  = 1'b0;
      mem_wr  = 1'b0;
      ir_we   = 1'b0;
      pc_we   = 1'b0;
      pc_src  = 2'b00;
      reg_we  = 1'b0;
      wb_sel  = 1'b0;
      halted  = 1'b0;
      illegal = 1'b0;
      case (r_state)
         S_FETCH: begin
            mem_rd = 1'b1;
            if (mem_ready) begin
               ir_we  = 1'b1;
               pc_we  = 1'b1;
               pc_src = 2'b00;
            end
         end
         S_DECODE: begin
            if (w_is_jmp) begin
               pc_we  = 1'b1;
               pc_src = 2'b10;
            end else if (w_is_illegal) begin
               illegal = 1'b1;
            end
         end
         S_EXEC: begin
            if (w_is_alu) begin
               ULAOp = w_opcode[1:0];
            end else if (w_is_beq) begin
               // rd - rs; the branch is taken when the ULA reports zero
               ULAOp = 2'b01;
               if (zero) begin
                  pc_we  = 1'b1;
                  pc_src = 2'b01;
               end
            end else begin
               // LD/ST address is rs + 0
               ULAOp = 2'b00;
            end
         end
         S_MEM: begin
            // Only LD and ST reach MEM
            mem_rd = w_is_ld;
            mem_wr = !w_is_ld;
         end
         S_WB: begin
            reg_we = 1'b1;
            wb_sel = w_is_ld;
         end
         S_HALT: begin
            halted = 1'b1;
         end
         default: begin
            halted = 1'b0;
         end
      endcase
      if (reset) begin
         ULAOp   = 2'b00;
         mem_rd  = 1'b0;
         mem_wr  = 1'b0;
         ir_we   = 1'b0;
         pc_we   = 1'b0;
         pc_src  = 2'b00;
         reg_we  = 1'b0;
         wb_sel  = 1'b0;
         halted  = 1'b0;
         illegal = 1'b0;
      end
   end

   // Wait counter: counts idle request cycles; zero on any state change
   always_ff @(posedge c) begin
      if (reset) begin
         r_wait <= 8'd0;
      end else if (w_wait_state && !mem_ready && (w_next_state == r_state)) begin
         r_wait <= r_wait + 8'd1;
      end else begin
         r_wait <= 8'd0;
      end
   end

   // Sticky fault flag, cleared only by reset
   always_ff @(posedge c) begin
      if (reset) begin
         r_fault <= 1'b0;
      end else if (w_timeout) begin
         r_fault <= 1'b1;
      end
   end

   // Retired-instruction counter, wraps naturally
   always_ff @(posedge c) begin
      if (reset) begin
         r_retired <= '0;
      end else if (w_retire) begin
         r_retired <= r_retired + CNT_W'(1);
      end
   end

   assign fault     = r_fault && !reset;
   assign retired   = reset ? '0 : r_retired;
   assign dbg_state = reset ? 3'd0 : r_state;

endmodule

// File: tb/tb_ctrl_multiciclo.sv
// Testbench for ctrl_multiciclo. Each instruction is expanded into its
// expected cycle sequence from the instruction-level rules. The bench then
// drives that sequence cycle by cycle and compares the outputs.
module tb_ctrl_multiciclo;

   localparam int TIMEOUT = 6;
   localparam int CNT_W   = 6;

   // ---------------- clock / reset ----------------
   logic             c = 1'b0;
   logic             reset = 1'b1;
   logic [7:0]       instr = 8'h00;
   logic             zero = 1'b0;
   logic             mem_ready = 1'b0;
   logic [1:0]       ULAOp;
   logic             mem_rd, mem_wr, ir_we, pc_we;
   logic [1:0]       pc_src;
   logic             reg_we, wb_sel, halted, fault, illegal;
   logic [CNT_W-1:0] retired;
   logic [2:0]       dbg_state;

   always #5 c = ~c;

   ctrl_multiciclo #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
      .c(c), .reset(reset), .instr(instr), .zero(zero), .mem_ready(mem_ready),
      .ULAOp(ULAOp), .mem_rd(mem_rd), .mem_wr(mem_wr), .ir_we(ir_we),
      .pc_we(pc_we), .pc_src(pc_src), .reg_we(reg_we), .wb_sel(wb_sel),
      .halted(halted), .fault(fault), .illegal(illegal), .retired(retired),
      .dbg_state(dbg_state)
   );

   // Observed output vector: {ULAOp, rd, wr, ir_we, pc_we, pc_src, reg_we, wb_sel, halted, fault, illegal}
   logic [12:0] w_obs;
   assign w_obs = {ULAOp, mem_rd, mem_wr, ir_we, pc_we, pc_src, reg_we, wb_sel, halted, fault, illegal};

   int n_checks = 0;
   int n_errors = 0;

   // ---------------- reference model ----------------
   typedef struct {
      logic [7:0]  ins;
      logic        mr;
      logic        z;
      logic [12:0] exp;
      logic        ret;
      logic        tmo;
   } cyc_t;

   cyc_t             cyc_q[$];
   logic [CNT_W-1:0] m_retired = '0;
   logic             m_fault = 1'b0;

   function automatic logic [12:0] mk(input logic [1:0] ula, input logic rd, input logic wr,
                                      input logic ir, input logic pcw, input logic [1:0] src,
                                      input logic rw, input logic wbs, input logic hlt,
                                      input logic ill);
      return {ula, rd, wr, ir, pcw, src, rw, wbs, hlt, 1'b0, ill};
   endfunction

   // Expand one instruction into its expected cycles (fw/mw = idle cycles before ready)
   task automatic build_instr(input logic [7:0] ins, input int fw, input int mw, input logic z);
      cyc_t       cy;
      logic [3:0] op;
      logic [1:0] ula;
      logic       ill;
      logic       tkn;
      op = ins[7:4];
      for (int k = 0; k <= fw && k < TIMEOUT; k++) begin
         cy.ins = 8'($urandom);
         cy.z   = 1'($urandom);
         cy.mr  = (k == fw);
         cy.exp = mk(2'b00, 1'b1, 1'b0, cy.mr, cy.mr, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
         cy.ret = 1'b0;
         cy.tmo = !cy.mr && (k == TIMEOUT - 1);
         cyc_q.push_back(cy);
      end
      if (fw >= TIMEOUT) return;
      // decode
      ill    = (op >= 4'h8) && (op <= 4'hE);
      cy.ins = ins;
      cy.mr  = 1'($urandom);
      cy.z   = 1'($urandom);
      cy.ret = (op == 4'h7) || ill;
      cy.tmo = 1'b0;
      cy.exp = mk(2'b00, 1'b0, 1'b0, 1'b0, op == 4'h7, (op == 4'h7) ? 2'b10 : 2'b00,
                  1'b0, 1'b0, 1'b0, ill);
      cyc_q.push_back(cy);
      if (op >= 4'h7) return;
      // execute
      if (op <= 4'h3) ula = op[1:0];
      else if (op == 4'h6) ula = 2'b01;
      else ula = 2'b00;
      tkn    = (op == 4'h6) && z;
      cy.mr  = 1'($urandom);
      cy.z   = (op == 4'h6) ? z : 1'($urandom);
      cy.ret = (op == 4'h6);
      cy.exp = mk(ula, 1'b0, 1'b0, 1'b0, tkn, tkn ? 2'b01 : 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc_q.push_back(cy);
      if (op == 4'h6) return;
      // memory
      if (op == 4'h4 || op == 4'h5) begin
         for (int k = 0; k <= mw && k < TIMEOUT; k++) begin
            cy.mr  = (k == mw);
            cy.z   = 1'($urandom);
            cy.exp = mk(2'b00, op == 4'h4, op == 4'h5, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
            cy.ret = cy.mr && (op == 4'h5);
            cy.tmo = !cy.mr && (k == TIMEOUT - 1);
            cyc_q.push_back(cy);
         end
         if (mw >= TIMEOUT || op == 4'h5) return;
      end
      // write-back
      cy.mr  = 1'($urandom);
      cy.z   = 1'($urandom);
      cy.ret = 1'b1;
      cy.tmo = 1'b0;
      cy.exp = mk(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, op == 4'h4, 1'b0, 1'b0);
      cyc_q.push_back(cy);
   endtask

   // n cycles parked in HALT with arbitrary input activity
   task automatic build_halt(input int n);
      cyc_t cy;
      for (int k = 0; k < n; k++) begin
         cy.ins = 8'($urandom);
         cy.mr  = 1'($urandom);
         cy.z   = 1'($urandom);
         cy.exp = mk(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
         cy.ret = 1'b0;
         cy.tmo = 1'b0;
         cyc_q.push_back(cy);
      end
   endtask

   // ---------------- driver / scoreboard ----------------
   task automatic play(input string tag);
      cyc_t        cy;
      logic [12:0] exp;
      while (cyc_q.size() > 0) begin
         cy        = cyc_q.pop_front();
         instr     = cy.ins;
         mem_ready = cy.mr;
         zero      = cy.z;
         exp       = cy.exp;
         exp[1]    = m_fault;
         @(negedge c);
         n_checks++;
         if (w_obs !== exp) begin
            n_errors++;
            $display("FAIL %s outputs instr=%h got %b exp %b", tag, cy.ins, w_obs, exp);
         end
         n_checks++;
         if (retired !== m_retired) begin
            n_errors++;
            $display("FAIL %s retired got %0d exp %0d", tag, retired, m_retired);
         end
         @(posedge c); #1;
         if (cy.ret) m_retired = m_retired + 1'b1;
         if (cy.tmo) m_fault = 1'b1;
      end
   endtask

   task automatic do_reset(input int n);
      reset = 1'b1;
      for (int k = 0; k < n; k++) begin
         instr = 8'($urandom); mem_ready = 1'($urandom); zero = 1'($urandom);
         @(posedge c); #1;
      end
      reset = 1'b0; instr = 8'h00; mem_ready = 1'b0; zero = 1'b0;
      m_retired = '0;
      m_fault   = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset = 1'b1;
      @(posedge c); #1;
      for (int k = 0; k < 3; k++) begin
         instr = 8'($urandom); mem_ready = 1'($urandom); zero = 1'($urandom);
         @(negedge c);
         n_checks++;
         if (w_obs !== 13'd0 || retired !== '0) begin
            n_errors++;
            $display("FAIL reset_outputs got %b/%0d exp 0/0", w_obs, retired);
         end
         @(posedge c); #1;
      end
      reset = 1'b0; mem_ready = 1'b0; instr = 8'h00; zero = 1'b0;
      m_retired = '0; m_fault = 1'b0;
      #1;
      n_checks++;
      if (w_obs !== mk(2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0)) begin
         n_errors++;
         $display("FAIL reset_fetch got %b exp fetch request only", w_obs);
      end
   endtask

   task automatic test_alu();
      build_instr(8'h06, 0, 0, 1'b0);
      play("add");
      n_checks++;
      if (retired !== CNT_W'(1)) begin
         n_errors++;
         $display("FAIL add_retired got %0d exp 1", retired);
      end
      build_instr(8'h16, 1, 0, 1'b0);
      build_instr(8'h2B, 0, 0, 1'b1);
      build_instr(8'h3C, 2, 0, 1'b0);
      play("alu");
   endtask

   task automatic test_load_store();
      build_instr(8'h49, 0, 3, 1'b0);
      play("ld");
      build_instr(8'h5E, 0, 0, 1'b0);
      build_instr(8'h52, 1, 2, 1'b1);
      build_instr(8'h43, 0, 0, 1'b1);
      play("ldst");
   endtask

   task automatic test_branch_jump();
      build_instr(8'h61, 0, 0, 1'b1);
      build_instr(8'h61, 0, 0, 1'b0);
      build_instr(8'h7A, 0, 0, 1'b0);
      build_instr(8'h74, 2, 0, 1'b1);
      play("beq_jmp");
   endtask

   task automatic test_illegal_halt();
      do_reset(1);
      build_instr(8'h9A, 0, 0, 1'b0);
      build_instr(8'hE1, 1, 0, 1'b0);
      build_instr(8'hF0, 0, 0, 1'b0);
      build_halt(8);
      play("ill_halt");
      #1;
      n_checks++;
      if (halted !== 1'b1 || retired !== CNT_W'(2) || fault !== 1'b0) begin
         n_errors++;
         $display("FAIL halt_state got h=%b r=%0d f=%b exp h=1 r=2 f=0", halted, retired, fault);
      end
   endtask

   task automatic test_timeout();
      do_reset(1);
      // ready on the last allowed cycle still completes
      build_instr(8'h05, TIMEOUT - 1, 0, 1'b0);
      build_instr(8'h46, 0, TIMEOUT - 1, 1'b0);
      // LD that never gets ready in MEM
      build_instr(8'h47, 0, TIMEOUT, 1'b0);
      build_halt(4);
      play("tmo_mem");
      #1;
      n_checks++;
      if (fault !== 1'b1 || halted !== 1'b1 || mem_rd !== 1'b0 || retired !== CNT_W'(2)) begin
         n_errors++;
         $display("FAIL tmo_mem_state got f=%b h=%b rd=%b r=%0d exp 1 1 0 2", fault, halted, mem_rd, retired);
      end
      do_reset(1);
      #1;
      n_checks++;
      if (fault !== 1'b0 || retired !== '0 || halted !== 1'b0 || mem_rd !== 1'b1) begin
         n_errors++;
         $display("FAIL tmo_reset got f=%b r=%0d h=%b rd=%b exp 0 0 0 1", fault, retired, halted, mem_rd);
      end
      // fetch that never gets ready
      build_instr(8'h00, TIMEOUT, 0, 1'b0);
      build_halt(3);
      play("tmo_fetch");
      do_reset(1);
   endtask

   task automatic test_reset_mid_st();
      build_instr(8'h1B, 0, 0, 1'b0);
      play("mid_pre");
      instr = 8'($urandom); mem_ready = 1'b1; zero = 1'($urandom);
      @(negedge c);
      n_checks++;
      if (w_obs !== mk(2'b00, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0)) begin
         n_errors++;
         $display("FAIL mid_fetch got %b", w_obs);
      end
      @(posedge c); #1;
      instr = 8'h5D; mem_ready = 1'b0;
      for (int k = 0; k < 2; k++) begin
         @(negedge c);
         n_checks++;
         if (w_obs !== 13'd0) begin
            n_errors++;
            $display("FAIL mid_dec_exec got %b exp 0", w_obs);
         end
         @(posedge c); #1;
      end
      for (int k = 0; k < 2; k++) begin
         @(negedge c);
         n_checks++;
         if (w_obs !== mk(2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0)) begin
            n_errors++;
            $display("FAIL mid_mem got %b exp store request", w_obs);
         end
         @(posedge c); #1;
      end
      reset = 1'b1; mem_ready = 1'b1;
      @(negedge c);
      n_checks++;
      if (w_obs !== 13'd0 || retired !== '0) begin
         n_errors++;
         $display("FAIL mid_rst got %b/%0d exp 0/0", w_obs, retired);
      end
      @(posedge c); #1;
      reset = 1'b0; mem_ready = 1'b0;
      m_retired = '0; m_fault = 1'b0;
      build_instr(8'h2F, 0, 0, 1'b0);
      play("mid_post");
      n_checks++;
      if (retired !== CNT_W'(1)) begin
         n_errors++;
         $display("FAIL mid_retired got %0d exp 1", retired);
      end
   endtask

   task automatic test_random();
      logic [3:0] op;
      int         fw;
      int         mw;
      do_reset(2);
      for (int n = 0; n < 90; n++) begin
         op = 4'($urandom_range(0, 14));
         fw = ($urandom_range(0, 7) == 0) ? TIMEOUT - 1 : $urandom_range(0, 2);
         mw = ($urandom_range(0, 7) == 0) ? TIMEOUT - 1 : $urandom_range(0, 2);
         build_instr({op, 4'($urandom)}, fw, mw, 1'($urandom));
         play("rand");
      end
      #1;
      n_checks++;
      if (retired !== CNT_W'(90 % (1 << CNT_W))) begin
         n_errors++;
         $display("FAIL rand_wrap got %0d exp %0d", retired, 90 % (1 << CNT_W));
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_alu();
      test_load_store();
      test_branch_jump();
      test_illegal_halt();
      test_timeout();
      test_reset_mid_st();
      test_random();
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
